// File: rtl/tic_tac_toe_engine.sv
// tic_tac_toe_engine
//   Two-player tic-tac-toe referee. Validates moves from the player on turn,
//   marks the board, checks the 8 lines after every accepted move, and holds
//   the result in a terminal state until new_game or reset.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   new_game          - synchronous restart (same effect as reset)
//   move_valid_A/B    - player A/B presents a move
//   move_A/B          - cell index 0..8
//   board             - cell i at [2i+1:2i]; 10 empty, 01 A, 00 B
//   turn              - 1 = A to move, 0 = B to move
//   move_ready        - high in PLAY
//   move_accepted     - pulse for a legal move (same cycle it is presented)
//   illegal_move      - pulse for a rejected move from the on-turn player
//   move_count        - marks on the board
//   game_over, winner - result (winner 01 A, 00 B, 10 none/draw)
module tic_tac_toe_engine #(
    parameter logic FIRST_PLAYER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid_A,
    input  logic [3:0]  move_A,
    input  logic        move_valid_B,
    input  logic [3:0]  move_B,
    output logic [17:0] board,
    output logic        turn,
    output logic        move_ready,
    output logic        move_accepted,
    output logic        illegal_move,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        PLAY  = 3'd0,
        CHECK = 3'd1,
        A_WIN = 3'd2,
        B_WIN = 3'd3,
        DRAW  = 3'd4
    } state_t;

    localparam logic [17:0] EMPTY_BOARD = 18'h2AAAA;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  count_q, count_d;

    logic       on_valid;
    logic [3:0] on_pos;
    logic [1:0] on_cell;
    logic [1:0] mark;
    logic       legal;
    logic [8:0] hit;
    logic       win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            board_q <= EMPTY_BOARD;
            turn_q  <= FIRST_PLAYER;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            turn_q  <= turn_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        // Only the on-turn player is looked at; the other side is ignored.
        on_valid = turn_q ? move_valid_A : move_valid_B;
        on_pos   = turn_q ? move_A : move_B;
        mark     = turn_q ? 2'b01 : 2'b00;

        // Out-of-range positions read back as "occupied" so they fail legality.
        on_cell = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (on_pos == 4'(i)) on_cell = board_q[2*i +: 2];
        end
        legal = on_valid && (on_pos <= 4'd8) && (on_cell == 2'b10);

        // In CHECK, turn_q still names the player who just moved.
        for (int i = 0; i < 9; i++) begin
            hit[i] = (board_q[2*i +: 2] == mark);
        end
        win = (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
              (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
              (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
              (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        turn_d  = turn_q;
        count_d = count_q;

        move_accepted = 1'b0;
        illegal_move  = 1'b0;

        if (new_game) begin
            // Any move in the same cycle is dropped without a pulse.
            state_d = PLAY;
            board_d = EMPTY_BOARD;
            turn_d  = FIRST_PLAYER;
            count_d = 4'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (legal) begin
                        move_accepted = !reset;
                        for (int i = 0; i < 9; i++) begin
                            if (on_pos == 4'(i)) board_d[2*i +: 2] = mark;
                        end
                        count_d = count_q + 4'd1;
                        state_d = CHECK;
                    end else if (on_valid) begin
                        illegal_move = !reset;
                    end
                end
                CHECK: begin
                    // Win is tested before the full-board draw.
                    if (win)                  state_d = turn_q ? A_WIN : B_WIN;
                    else if (count_q == 4'd9) state_d = DRAW;
                    else begin
                        state_d = PLAY;
                        turn_d  = !turn_q;
                    end
                end
                A_WIN, B_WIN, DRAW: ;
                default: state_d = PLAY;
            endcase
        end
    end

    assign board      = board_q;
    assign turn       = turn_q;
    assign move_count = count_q;
    assign move_ready = (state_q == PLAY);
    assign game_over  = (state_q == A_WIN) || (state_q == B_WIN) || (state_q == DRAW);
    assign winner     = (state_q == A_WIN) ? 2'b01 :
                        (state_q == B_WIN) ? 2'b00 : 2'b10;

endmodule

// File: tb/tb_tic_tac_toe_engine.sv
module tb_tic_tac_toe_engine;

    logic        clk = 1'b0;
    logic        reset, new_game;
    logic        move_valid_A, move_valid_B;
    logic [3:0]  move_A, move_B;
    logic [17:0] board;
    logic        turn, move_ready, move_accepted, illegal_move, game_over;
    logic [3:0]  move_count;
    logic [1:0]  winner;

    int errors = 0;
    int checks = 0;

    // 1 = expect accept pulse, 0 = expect illegal pulse
    bit exp_q[$];

    logic [17:0] exp_board;
    int          exp_cnt;

    tic_tac_toe_engine dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid_A(move_valid_A), .move_A(move_A),
        .move_valid_B(move_valid_B), .move_B(move_B),
        .board(board), .turn(turn), .move_ready(move_ready),
        .move_accepted(move_accepted), .illegal_move(illegal_move),
        .move_count(move_count), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        if (move_accepted || illegal_move) begin
            bit e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: acc=%0b ill=%0b, expected no pulse",
                         move_accepted, illegal_move);
            end else begin
                e = exp_q.pop_front();
                if (move_accepted !== e || illegal_move !== !e) begin
                    errors++;
                    $display("FAIL pulse: acc=%0b ill=%0b, expected acc=%0b ill=%0b",
                             move_accepted, illegal_move, e, !e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic t, input logic over,
                              input logic [1:0] w, input logic rdy);
        chk({name, ".board"}, 32'(board), 32'(exp_board));
        chk({name, ".count"}, 32'(move_count), 32'(exp_cnt));
        chk({name, ".turn"}, 32'(turn), 32'(t));
        chk({name, ".over"}, 32'(game_over), 32'(over));
        chk({name, ".winner"}, 32'(winner), 32'(w));
        chk({name, ".ready"}, 32'(move_ready), 32'(rdy));
    endtask

    task automatic clear_model();
        exp_board = 18'h2AAAA;
        exp_cnt   = 0;
    endtask

    // Present one move for one cycle; legal moves also wait out CHECK.
    task automatic mv(input bit pl, input int pos, input bit legal);
        if (pl) begin move_valid_A = 1'b1; move_A = 4'(pos); end
        else    begin move_valid_B = 1'b1; move_B = 4'(pos); end
        exp_q.push_back(legal);
        @(posedge clk); #1;
        move_valid_A = 1'b0; move_valid_B = 1'b0;
        if (legal) begin
            exp_board[2*pos +: 2] = pl ? 2'b01 : 2'b00;
            exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        clear_model();
    endtask

    task automatic play_seq(input int seq[9]);
        for (int i = 0; i < 9; i++) mv(i % 2 == 0, seq[i], 1'b1);
    endtask

    int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win9_seq[9] = '{0, 3, 2, 5, 4, 6, 7, 8, 1};

    initial begin
        reset = 1'b1; new_game = 1'b0;
        move_valid_A = 1'b0; move_valid_B = 1'b0; move_A = 4'd0; move_B = 4'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk_status("reset", 1'b1, 1'b0, 2'b10, 1'b1);

        // A wins on the top row
        mv(1, 0, 1); mv(0, 3, 1); mv(1, 1, 1); mv(0, 4, 1);
        chk_status("mid_game", 1'b1, 1'b0, 2'b10, 1'b1);
        mv(1, 2, 1);
        chk_status("a_row_win", 1'b1, 1'b1, 2'b01, 1'b0);

        // Terminal state ignores moves with no pulses
        move_valid_A = 1'b1; move_A = 4'd5; move_valid_B = 1'b1; move_B = 4'd6;
        repeat (2) @(posedge clk);
        #1 move_valid_A = 1'b0; move_valid_B = 1'b0;
        chk_status("terminal_hold", 1'b1, 1'b1, 2'b01, 1'b0);

        do_new_game();
        chk_status("new_game_awin", 1'b1, 1'b0, 2'b10, 1'b1);

        // new_game with a move in the same cycle: move discarded
        new_game = 1'b1; move_valid_A = 1'b1; move_A = 4'd4;
        @(posedge clk); #1;
        new_game = 1'b0; move_valid_A = 1'b0;
        chk_status("new_game_drop", 1'b1, 1'b0, 2'b10, 1'b1);

        // Occupied cell rejected, then retry elsewhere
        mv(1, 4, 1);
        mv(0, 4, 0);
        chk_status("occupied", 1'b0, 1'b0, 2'b10, 1'b1);
        chk("cell4", 32'(board[9:8]), 32'h1);
        mv(0, 8, 1);
        chk_status("retry", 1'b1, 1'b0, 2'b10, 1'b1);

        // Out-of-range pos on A's turn; B's simultaneous move ignored
        do_new_game();
        move_valid_A = 1'b1; move_A = 4'd9; move_valid_B = 1'b1; move_B = 4'd0;
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        move_valid_A = 1'b0; move_valid_B = 1'b0;
        chk_status("range", 1'b1, 1'b0, 2'b10, 1'b1);

        // Full board, no line
        do_new_game();
        play_seq(draw_seq);
        chk_status("draw", 1'b1, 1'b1, 2'b10, 1'b0);

        // Ninth move completes a line: win over draw
        do_new_game();
        play_seq(win9_seq);
        chk_status("win9", 1'b1, 1'b1, 2'b01, 1'b0);

        // Reset while in CHECK
        do_new_game();
        mv(1, 0, 1); mv(0, 3, 1);
        move_valid_A = 1'b1; move_A = 4'd1;
        exp_q.push_back(1'b1);
        @(posedge clk); #1;
        move_valid_A = 1'b0;
        chk("in_check.ready", 32'(move_ready), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        chk_status("reset_check", 1'b1, 1'b0, 2'b10, 1'b1);

        // new_game from A_WIN
        mv(1, 0, 1); mv(0, 3, 1); mv(1, 1, 1); mv(0, 4, 1); mv(1, 2, 1);
        chk("awin2.winner", 32'(winner), 32'h1);
        do_new_game();
        chk_status("new_game_awin2", 1'b1, 1'b0, 2'b10, 1'b1);

        repeat (3) @(posedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
